// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD datapath: digit width, FSM states
// and the two per-digit helpers used by the adder and the operand checker.
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADD,
    ST_FIX
  } state_e;

  function automatic logic [BCD_W-1:0] nines_comp(input logic [BCD_W-1:0] d);
    return 4'd9 - d;
  endfunction

  function automatic logic bcd_invalid(input logic [BCD_W-1:0] d);
    return d > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// One-digit BCD adder: binary sum of two digits plus carry, corrected by +6
// whenever the raw sum leaves the decimal range.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] x,
  input  logic [BCD_W-1:0] y,
  input  logic             cin,
  output logic [BCD_W-1:0] s,
  output logic             cout
);

  logic [BCD_W:0] rawSum;

  // Wrapping the 4-bit +6 drops the decimal ten exactly as the correction needs.
  always_comb begin
    rawSum = {1'b0, x} + {1'b0, y} + {{BCD_W{1'b0}}, cin};
    if (rawSum > 5'd9) begin
      s    = rawSum[BCD_W-1:0] + 4'd6;
      cout = 1'b1;
    end else begin
      s    = rawSum[BCD_W-1:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor returning sign-magnitude. Negative
// differences get a second serial 10's-complement pass through the same adder.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    mode,
  input  logic [BCD_W*DIGITS-1:0] a,
  input  logic [BCD_W*DIGITS-1:0] b,
  output logic [BCD_W*DIGITS-1:0] result,
  output logic                    carry,
  output logic                    neg,
  output logic                    err,
  output logic                    busy,
  output logic                    done
);

  localparam int W = BCD_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             c_q;
  logic             modeReg_q;
  logic             invalid_q;
  logic [W-1:0]     aReg_q;
  logic [W-1:0]     bReg_q;
  logic [W-1:0]     result_q;
  logic             carry_q;
  logic             neg_q;
  logic             err_q;
  logic             busy_q;
  logic             done_q;

  logic             opInvalid;
  logic [BCD_W-1:0] curA;
  logic [BCD_W-1:0] curB;
  logic [BCD_W-1:0] curR;
  logic [BCD_W-1:0] addX;
  logic [BCD_W-1:0] addY;
  logic [BCD_W-1:0] sumDigit;
  logic             sumCarry;
  logic [W-1:0]     resultUpd;

  always_comb begin
    opInvalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_invalid(a[i*BCD_W +: BCD_W]) || bcd_invalid(b[i*BCD_W +: BCD_W])) begin
        opInvalid = 1'b1;
      end
    end
  end

  // The FIX pass reuses the adder as (9 - r) + 0 + c on the result digits.
  always_comb begin
    curA = aReg_q[idx_q*BCD_W +: BCD_W];
    curB = bReg_q[idx_q*BCD_W +: BCD_W];
    curR = result_q[idx_q*BCD_W +: BCD_W];
    if (state_q == ST_FIX) begin
      addX = nines_comp(curR);
      addY = '0;
    end else begin
      addX = curA;
      addY = modeReg_q ? nines_comp(curB) : curB;
    end
  end

  bcd_digit_adder u_digit_adder (
    .x    (addX),
    .y    (addY),
    .cin  (c_q),
    .s    (sumDigit),
    .cout (sumCarry)
  );

  always_comb begin
    resultUpd = result_q;
    resultUpd[idx_q*BCD_W +: BCD_W] = sumDigit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      c_q       <= 1'b0;
      modeReg_q <= 1'b0;
      invalid_q <= 1'b0;
      aReg_q    <= '0;
      bReg_q    <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      neg_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            aReg_q    <= a;
            bReg_q    <= b;
            modeReg_q <= mode;
            invalid_q <= opInvalid;
            c_q       <= mode;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            neg_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= ST_ADD;
          end
        end
        ST_ADD: begin
          c_q <= sumCarry;
          if (idx_q == LAST_IDX) begin
            idx_q <= '0;
            if (invalid_q) begin
              result_q <= '0;
              err_q    <= 1'b1;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= ST_IDLE;
            end else if (!modeReg_q || sumCarry) begin
              result_q <= resultUpd;
              carry_q  <= !modeReg_q && sumCarry;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= ST_IDLE;
            end else begin
              // No end-around carry means A < B: recomplement the result.
              result_q <= resultUpd;
              c_q      <= 1'b1;
              state_q  <= ST_FIX;
            end
          end else begin
            result_q <= resultUpd;
            idx_q    <= idx_q + 1'b1;
          end
        end
        ST_FIX: begin
          result_q <= resultUpd;
          c_q      <= sumCarry;
          if (idx_q == LAST_IDX) begin
            idx_q   <= '0;
            neg_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign carry  = carry_q;
  assign neg    = neg_q;
  assign err    = err_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Scoreboard bench for bcd_serial_addsub: an integer reference model predicts each
// operation, per-instance monitors pop and compare whenever done pulses.
module tb_bcd_serial_addsub;

  typedef struct {
    logic [15:0] res;
    logic        carry;
    logic        neg;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start4 = 1'b0, mode4 = 1'b0;
  logic [15:0] a4 = '0, b4 = '0;
  logic [15:0] result4;
  logic        carry4, neg4, err4, busy4, done4;
  logic        start1 = 1'b0, mode1 = 1'b0;
  logic [3:0]  a1 = '0, b1 = '0;
  logic [3:0]  result1;
  logic        carry1, neg1, err1, busy1, done1;

  int   nAssert = 0;
  int   nFail = 0;
  int   cycleCnt = 0;
  exp_t q4[$];
  exp_t q1[$];

  bcd_serial_addsub #(.DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .a(a4), .b(b4),
    .result(result4), .carry(carry4), .neg(neg4), .err(err4), .busy(busy4), .done(done4)
  );

  bcd_serial_addsub #(.DIGITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .a(a1), .b(b1),
    .result(result1), .carry(carry1), .neg(neg1), .err(err1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    nAssert++;
    if (act !== expv) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Reference model: plain decimal arithmetic on the decoded operands.
  function automatic exp_t refModel(input logic [15:0] av, input logic [15:0] bv,
                                    input logic m, input int d);
    exp_t e;
    int   x = 0, y = 0, p = 1, val = 0, da, db;
    bit   bad = 0;
    for (int i = 0; i < d; i++) begin
      da = int'((av >> (4 * i)) & 16'hF);
      db = int'((bv >> (4 * i)) & 16'hF);
      if (da > 9 || db > 9) bad = 1;
      x += da * p;
      y += db * p;
      p *= 10;
    end
    e.carry = 0; e.neg = 0; e.err = 0; e.lat = d; e.acc = 0;
    if (bad) begin
      e.err = 1;
      val = 0;
    end else if (!m) begin
      e.carry = (x + y) >= p;
      val = (x + y) % p;
    end else if (x >= y) begin
      val = x - y;
    end else begin
      val = y - x;
      e.neg = 1;
      e.lat = 2 * d;
    end
    e.res = '0;
    for (int i = 0; i < d; i++) begin
      e.res[4*i +: 4] = 4'(val % 10);
      val = val / 10;
    end
    return e;
  endfunction

  function automatic logic [15:0] randBcd(input bit allowBad);
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      v[4*i +: 4] = 4'($urandom_range(0, 9));
      if (allowBad && $urandom_range(0, 15) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
    end
    return v;
  endfunction

  always @(negedge clk) begin : mon4
    exp_t e;
    if (rst_n && done4) begin
      checkOutput("dut4_done_expected", (q4.size() > 0) ? 1 : 0, 1);
      if (q4.size() > 0) begin
        e = q4.pop_front();
        checkOutput("dut4_result", result4, e.res);
        checkOutput("dut4_carry", carry4, e.carry);
        checkOutput("dut4_neg", neg4, e.neg);
        checkOutput("dut4_err", err4, e.err);
        checkOutput("dut4_busy_at_done", busy4, 0);
        checkOutput("dut4_latency", cycleCnt - e.acc, e.lat);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_n && done1) begin
      checkOutput("dut1_done_expected", (q1.size() > 0) ? 1 : 0, 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        checkOutput("dut1_result", result1, e.res[3:0]);
        checkOutput("dut1_carry", carry1, e.carry);
        checkOutput("dut1_neg", neg1, e.neg);
        checkOutput("dut1_err", err1, e.err);
        checkOutput("dut1_latency", cycleCnt - e.acc, e.lat);
      end
    end
  end

  // Called at a negedge; returns at the negedge where done is seen, so a
  // following call asserts start in the done cycle (back-to-back).
  task automatic applyStimulus(input int sel, input logic [15:0] av, input logic [15:0] bv,
                               input logic m, input bit poke);
    exp_t e;
    int   d = (sel == 1) ? 1 : 4;
    int   waited = 0;
    e = refModel(av, bv, m, d);
    if (sel == 1) begin
      a1 = av[3:0]; b1 = bv[3:0]; mode1 = m; start1 = 1'b1;
    end else begin
      a4 = av; b4 = bv; mode4 = m; start4 = 1'b1;
    end
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start4 = 1'b0;
    e.acc = cycleCnt;
    if (sel == 1) q1.push_back(e); else q4.push_back(e);
    checkOutput("busy_after_accept", (sel == 1) ? busy1 : busy4, 1);
    if (poke && sel != 1) begin
      repeat (2) @(negedge clk);
      waited = 2;
      a4 = 16'h9999; b4 = 16'h0001; mode4 = ~m; start4 = 1'b1;
      @(negedge clk);
      waited++;
      start4 = 1'b0;
      if (done4) return;
    end
    do begin
      @(negedge clk);
      waited++;
    end while (!((sel == 1) ? done1 : done4) && waited < 3 * d + 4);
    if (!((sel == 1) ? done1 : done4)) checkOutput("done_timeout", 0, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_result", result4, 0);
    checkOutput("reset_carry", carry4, 0);
    checkOutput("reset_neg", neg4, 0);
    checkOutput("reset_err", err4, 0);
    checkOutput("reset_busy", busy4, 0);
    checkOutput("reset_done", done4, 0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(0, 16'h1234, 16'h5678, 1'b0, 0);
    applyStimulus(0, 16'h9999, 16'h0001, 1'b0, 0);
    applyStimulus(0, 16'h5000, 16'h1234, 1'b1, 0);
    applyStimulus(0, 16'h1234, 16'h5000, 1'b1, 0);
    applyStimulus(0, 16'h0000, 16'h0000, 1'b1, 0);
    applyStimulus(0, 16'h12A4, 16'h0001, 1'b0, 1);
    applyStimulus(0, 16'h0001, 16'h9999, 1'b1, 1);
    @(negedge clk);

    // Abort a negative subtract in its recomplement pass.
    a4 = 16'h1234; b4 = 16'h5000; mode4 = 1'b1; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_result", result4, 0);
    checkOutput("abort_neg", neg4, 0);
    checkOutput("abort_carry", carry4, 0);
    checkOutput("abort_busy", busy4, 0);
    checkOutput("abort_done", done4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    applyStimulus(0, 16'h1234, 16'h5678, 1'b0, 0);
    applyStimulus(0, 16'h4321, 16'h8765, 1'b1, 0);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, randBcd(1), randBcd(1), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0));
    end
    @(negedge clk);

    applyStimulus(1, 16'h0007, 16'h0005, 1'b0, 0);
    applyStimulus(1, 16'h0003, 16'h0008, 1'b1, 0);
    applyStimulus(1, 16'h000B, 16'h0002, 1'b0, 0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, randBcd(1), randBcd(1), 1'($urandom_range(0, 1)), 0);
    end

    repeat (5) @(negedge clk);
    checkOutput("dut4_queue_drained", q4.size(), 0);
    checkOutput("dut1_queue_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
